// File: rtl/frac_tick_gen_pkg.sv
// Shared types and default rates for the fractional tick generator.
// Default increments are derived from the core, rtc and uart frequencies.
package frac_tick_gen_pkg;

    localparam int unsigned ACC_WIDTH_MAX = 32;

    localparam longint unsigned CLK_FREQ = 64'd20_000_000;
    localparam longint unsigned RTC_FREQ = 64'd32_768;
    localparam longint unsigned BAUDRATE = 64'd115_200;

    localparam logic MODE_INT  = 1'b0;
    localparam logic MODE_FRAC = 1'b1;

    typedef struct packed {
        logic                     en;
        logic                     mode;
        logic [ACC_WIDTH_MAX-1:0] inc;
    } tick_cfg_t;

    typedef enum logic [1:0] {
        ACC_CLEAR,
        ACC_FRAC,
        ACC_INT
    } acc_op_e;

    // round(2^ACC_WIDTH_MAX * freq / CLK_FREQ)
    function automatic logic [ACC_WIDTH_MAX-1:0] rate_inc(
        input longint unsigned freq
    );
        longint unsigned num;
        num = (freq << ACC_WIDTH_MAX) + CLK_FREQ / 2;
        return ACC_WIDTH_MAX'(num / CLK_FREQ);
    endfunction

    localparam logic [ACC_WIDTH_MAX-1:0] RTC_INC  = rate_inc(RTC_FREQ);
    localparam logic [ACC_WIDTH_MAX-1:0] BAUD_INC = rate_inc(BAUDRATE);

endpackage

// File: rtl/frac_tick_gen_channel.sv
// One tick channel: config registers, accumulator/divider, tick and
// free-running tick counter.
module tick_channel
    import frac_tick_gen_pkg::*;
#(
    parameter int                   ACC_WIDTH = 32,
    parameter logic                 DEF_MODE  = MODE_FRAC,
    parameter logic [ACC_WIDTH-1:0] DEF_INC   = '0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  tick_cfg_t   cfg,
    output logic        tick,
    output logic [15:0] tick_cnt
);

    logic                 en_q;
    logic                 mode_q;
    logic [ACC_WIDTH-1:0] inc_q;
    logic [ACC_WIDTH-1:0] acc_q;

    logic [ACC_WIDTH-1:0] acc_d;
    logic                 tick_d;
    logic [ACC_WIDTH:0]   sum;
    acc_op_e              op;

    always_comb begin
        if (load || clear || !en_q) begin
            op = ACC_CLEAR;
        end else if (mode_q == MODE_FRAC) begin
            op = ACC_FRAC;
        end else begin
            op = ACC_INT;
        end
    end

    // Carry out of the widened sum is the fractional tick.
    always_comb begin
        sum    = {1'b0, acc_q} + {1'b0, inc_q};
        acc_d  = '0;
        tick_d = 1'b0;
        unique case (op)
            ACC_CLEAR: begin
                acc_d  = '0;
                tick_d = 1'b0;
            end
            ACC_FRAC: begin
                acc_d  = sum[ACC_WIDTH-1:0];
                tick_d = sum[ACC_WIDTH];
            end
            ACC_INT: begin
                if (acc_q == inc_q) begin
                    acc_d  = '0;
                    tick_d = 1'b1;
                end else begin
                    acc_d  = acc_q + 1'b1;
                    tick_d = 1'b0;
                end
            end
            default: begin
                acc_d  = '0;
                tick_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            en_q     <= 1'b1;
            mode_q   <= DEF_MODE;
            inc_q    <= DEF_INC;
            acc_q    <= '0;
            tick     <= 1'b0;
            tick_cnt <= '0;
        end else begin
            if (load) begin
                en_q   <= cfg.en;
                mode_q <= cfg.mode;
                inc_q  <= cfg.inc[ACC_WIDTH-1:0];
            end
            acc_q <= acc_d;
            tick  <= tick_d;
            if (tick_d) begin
                tick_cnt <= tick_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/frac_tick_gen.sv
// Multi-channel clock-enable generator with integer or fractional rate
// per channel, runtime write port and global phase realign.
module frac_tick_gen
    import frac_tick_gen_pkg::*;
#(
    parameter int                           CHANNELS  = 2,
    parameter int                           ACC_WIDTH = 32,
    parameter logic [CHANNELS-1:0]          DEF_MODE  = {MODE_FRAC, MODE_FRAC},
    parameter logic [CHANNELS*ACC_WIDTH-1:0] DEF_INC  = {BAUD_INC, RTC_INC}
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cfg_we,
    input  logic [2:0]               cfg_ch,
    input  logic                     cfg_en,
    input  logic                     cfg_mode,
    input  logic [ACC_WIDTH-1:0]     cfg_inc,
    input  logic                     sync,
    output logic [CHANNELS-1:0]      tick,
    output logic [CHANNELS*16-1:0]   tick_cnt
);

    tick_cfg_t cfg_wr;

    assign cfg_wr = '{
        en:   cfg_en,
        mode: cfg_mode,
        inc:  ACC_WIDTH_MAX'(cfg_inc)
    };

    // Indices at or beyond CHANNELS match no channel, so the write drops.
    for (genvar c = 0; c < CHANNELS; c++) begin : gen_ch
        logic load;

        assign load = cfg_we && (cfg_ch == 3'(c));

        tick_channel #(
            .ACC_WIDTH (ACC_WIDTH),
            .DEF_MODE  (DEF_MODE[c]),
            .DEF_INC   (DEF_INC[c*ACC_WIDTH +: ACC_WIDTH])
        ) u_ch (
            .clock    (clock),
            .reset    (reset),
            .load     (load),
            .clear    (sync),
            .cfg      (cfg_wr),
            .tick     (tick[c]),
            .tick_cnt (tick_cnt[c*16 +: 16])
        );
    end

endmodule

// File: tb/tb_frac_tick_gen.sv
// Directed bench for frac_tick_gen: reset, default rates, integer and
// fractional modes, enable, bad index, sync and counter wrap.
module tb_frac_tick_gen;

    logic        clock = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [2:0]  cfg_ch;
    logic        cfg_en;
    logic        cfg_mode;
    logic [31:0] cfg_inc;
    logic        sync;
    logic [1:0]  tick;
    logic [31:0] tick_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    frac_tick_gen dut (
        .clock    (clock),
        .reset    (reset),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_en   (cfg_en),
        .cfg_mode (cfg_mode),
        .cfg_inc  (cfg_inc),
        .sync     (sync),
        .tick     (tick),
        .tick_cnt (tick_cnt)
    );

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_we   = 1'b0;
        cfg_ch   = 3'd0;
        cfg_en   = 1'b0;
        cfg_mode = 1'b0;
        cfg_inc  = 32'd0;
        sync     = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic wr(input logic [2:0] ch, input logic en,
                      input logic mode, input logic [31:0] inc);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_en   = en;
        cfg_mode = mode;
        cfg_inc  = inc;
        cyc();
        cfg_we   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #2;
        repeat (3) cyc();
        checks++;
        if (tick !== 2'b00) begin
            failures++;
            $display("FAIL reset_tick got=%b exp=00", tick);
        end
        checks++;
        if (tick_cnt !== 32'h0) begin
            failures++;
            $display("FAIL reset_cnt got=%h exp=00000000", tick_cnt);
        end
        reset = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        wr(3'd0, 1'b1, 1'b0, 32'd0);
        cyc();
        cyc();
        checks++;
        if (tick[0] !== 1'b1 || tick_cnt[15:0] !== 16'd2) begin
            failures++;
            $display("FAIL async_pre tick0=%b cnt0=%0d exp=1/2",
                     tick[0], tick_cnt[15:0]);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (tick !== 2'b00 || tick_cnt !== 32'h0) begin
            failures++;
            $display("FAIL async_reset tick=%b cnt=%h exp=00/0",
                     tick, tick_cnt);
        end
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_default_rates();
        int n0;
        int n1;
        n0 = 0;
        n1 = 0;
        do_reset();
        for (int i = 0; i < 5000; i++) begin
            cyc();
            n0 += int'(tick[0]);
            n1 += int'(tick[1]);
        end
        checks++;
        if (n0 != 8) begin
            failures++;
            $display("FAIL rate_ch0 ticks=%0d exp=8", n0);
        end
        checks++;
        if (n1 != 28) begin
            failures++;
            $display("FAIL rate_ch1 ticks=%0d exp=28", n1);
        end
        checks++;
        if (tick_cnt !== {16'd28, 16'd8}) begin
            failures++;
            $display("FAIL rate_cnt got=%h exp=001c0008", tick_cnt);
        end
    endtask

    task automatic test_int_div();
        logic exp;
        do_reset();
        wr(3'd0, 1'b1, 1'b0, 32'd3);
        checks++;
        if (tick[0] !== 1'b0) begin
            failures++;
            $display("FAIL int_load tick0=%b exp=0", tick[0]);
        end
        for (int i = 1; i <= 12; i++) begin
            cyc();
            exp = (i % 4 == 0);
            checks++;
            if (tick[0] !== exp) begin
                failures++;
                $display("FAIL int_div edge=%0d tick0=%b exp=%b",
                         i, tick[0], exp);
            end
        end
        checks++;
        if (tick_cnt[15:0] !== 16'd3) begin
            failures++;
            $display("FAIL int_cnt got=%0d exp=3", tick_cnt[15:0]);
        end
    endtask

    task automatic test_frac();
        logic exp;
        int   n;
        do_reset();
        wr(3'd1, 1'b1, 1'b1, 32'h4000_0000);
        for (int i = 1; i <= 8; i++) begin
            cyc();
            exp = (i % 4 == 0);
            checks++;
            if (tick[1] !== exp) begin
                failures++;
                $display("FAIL frac_quarter edge=%0d tick1=%b exp=%b",
                         i, tick[1], exp);
            end
        end
        wr(3'd1, 1'b1, 1'b1, 32'd0);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc();
            n += int'(tick[1]);
        end
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL frac_zero ticks=%0d exp=0", n);
        end
        checks++;
        if (tick_cnt[31:16] !== 16'd2) begin
            failures++;
            $display("FAIL frac_cnt got=%0d exp=2", tick_cnt[31:16]);
        end
    endtask

    task automatic test_disable();
        int n;
        logic e0;
        logic e1;
        do_reset();
        wr(3'd0, 1'b1, 1'b0, 32'd1);
        repeat (4) cyc();
        wr(3'd0, 1'b0, 1'b0, 32'd1);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            n += int'(tick[0]);
        end
        checks++;
        if (n != 0 || tick_cnt[15:0] !== 16'd2) begin
            failures++;
            $display("FAIL disable ticks=%0d cnt0=%0d exp=0/2",
                     n, tick_cnt[15:0]);
        end
        // ch0 period 5 from edge k, ch1 period 3 from edge k+1
        wr(3'd0, 1'b1, 1'b0, 32'd4);
        wr(3'd1, 1'b1, 1'b0, 32'd2);
        wr(3'd5, 1'b0, 1'b1, 32'd0);
        for (int i = 3; i <= 12; i++) begin
            cyc();
            e0 = (i % 5 == 0);
            e1 = (i == 4 || i == 7 || i == 10);
            checks++;
            if (tick !== {e1, e0}) begin
                failures++;
                $display("FAIL bad_index edge=%0d tick=%b exp=%b",
                         i, tick, {e1, e0});
            end
        end
    endtask

    task automatic test_sync();
        logic exp;
        logic e1;
        do_reset();
        wr(3'd0, 1'b1, 1'b0, 32'd9);
        repeat (6) cyc();
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            exp = (i == 10);
            checks++;
            if (tick[0] !== exp) begin
                failures++;
                $display("FAIL sync_realign edge=%0d tick0=%b exp=%b",
                         i, tick[0], exp);
            end
        end
        wr(3'd1, 1'b1, 1'b0, 32'd4);
        cyc();
        sync = 1'b1;
        wr(3'd0, 1'b1, 1'b0, 32'd2);
        sync = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            exp = (i == 3);
            e1  = (i == 5);
            checks++;
            if (tick !== {e1, exp}) begin
                failures++;
                $display("FAIL sync_write edge=%0d tick=%b exp=%b",
                         i, tick, {e1, exp});
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        wr(3'd0, 1'b1, 1'b0, 32'd0);
        repeat (65535) cyc();
        checks++;
        if (tick_cnt[15:0] !== 16'hFFFF || tick[0] !== 1'b1) begin
            failures++;
            $display("FAIL wrap_full cnt0=%h tick0=%b exp=ffff/1",
                     tick_cnt[15:0], tick[0]);
        end
        cyc();
        checks++;
        if (tick_cnt[15:0] !== 16'h0000 || tick[0] !== 1'b1) begin
            failures++;
            $display("FAIL wrap_zero cnt0=%h tick0=%b exp=0000/1",
                     tick_cnt[15:0], tick[0]);
        end
        cyc();
        checks++;
        if (tick_cnt[15:0] !== 16'h0001 || tick[0] !== 1'b1) begin
            failures++;
            $display("FAIL wrap_next cnt0=%h tick0=%b exp=0001/1",
                     tick_cnt[15:0], tick[0]);
        end
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_default_rates();
        test_int_div();
        test_frac();
        test_disable();
        test_sync();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
